scan_position_tracker: RTL and testbench

//  Companion to the main controller. Consumes the stage enables and the gaussian

---
 rtl/scan_position_tracker.sv | 122 ++++++++++++
 tb/tb_scan_position_tracker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/scan_position_tracker.sv
// Serpentine 9x9 read-window position tracker with four-stage pipeline fill sequencing.
// Position moves on enable9x9; fill states count right shifts per stage enable.
module scan_position_tracker #(
  parameter int XW         = 9,
  parameter int YW         = 9,
  parameter int XMAX       = 511,
  parameter int YMAX       = 511,
  parameter int GAUSS_FILL = 9,
  parameter int GRAD_FILL  = 7,
  parameter int SUPP_FILL  = 5,
  parameter int HYST_FILL  = 3
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          enable9x9,
  input  logic          enable7x7,
  input  logic          enable5x5,
  input  logic          enable3x3,
  input  logic [1:0]    gaussian_buffer,
  output logic [XW-1:0] readx,
  output logic [YW-1:0] ready,
  output logic          readx_up_max,
  output logic          readx_down_min,
  output logic          ready_max,
  output logic          gaussian_fill_done,
  output logic          gradient_fill_done,
  output logic          suppression_fill_done,
  output logic          hysteresis_fill_done
);
  localparam int CW = 4;
  localparam logic [CW-1:0] GAUSS_LAST = CW'(GAUSS_FILL - 1);
  localparam logic [CW-1:0] GRAD_LAST  = CW'(GRAD_FILL - 1);
  localparam logic [CW-1:0] SUPP_LAST  = CW'(SUPP_FILL - 1);
  localparam logic [CW-1:0] HYST_LAST  = CW'(HYST_FILL - 1);

  typedef enum logic [2:0] {IDLE, F_GAUSS, F_GRAD, F_SUPP, F_HYST, RUN} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] readx_q, readx_d;
  logic [YW-1:0] ready_q, ready_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          shift_right;
  logic          qual;
  logic [CW-1:0] last_cnt;
  logic          fill_last;

  assign shift_right = (gaussian_buffer == 2'b01);

  always_comb begin
    qual     = 1'b0;
    last_cnt = '0;
    case (state_q)
      F_GAUSS: begin qual = enable9x9 && shift_right; last_cnt = GAUSS_LAST; end
      F_GRAD:  begin qual = enable7x7 && shift_right; last_cnt = GRAD_LAST;  end
      F_SUPP:  begin qual = enable5x5 && shift_right; last_cnt = SUPP_LAST;  end
      F_HYST:  begin qual = enable3x3 && shift_right; last_cnt = HYST_LAST;  end
      default: begin qual = 1'b0;                    last_cnt = '0;         end
    endcase
    fill_last = qual && (cnt_q == last_cnt);
  end

  assign gaussian_fill_done    = (state_q == F_GAUSS) && fill_last;
  assign gradient_fill_done    = (state_q == F_GRAD)  && fill_last;
  assign suppression_fill_done = (state_q == F_SUPP)  && fill_last;
  assign hysteresis_fill_done  = (state_q == F_HYST)  && fill_last;

  assign readx          = readx_q;
  assign ready          = ready_q;
  assign readx_up_max   = (state_q == RUN) && (readx_q == XW'(XMAX));
  assign readx_down_min = (state_q == RUN) && (readx_q == '0);
  assign ready_max      = (state_q == RUN) && (ready_q == YW'(YMAX));

  always_comb begin
    state_d = state_q;
    readx_d = readx_q;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    if (enable9x9) begin
      case (gaussian_buffer)
        2'b01:   if (readx_q != XW'(XMAX)) readx_d = readx_q + 1'b1;
        2'b10:   if (readx_q != '0)        readx_d = readx_q - 1'b1;
        2'b11:   if (ready_q != YW'(YMAX)) ready_d = ready_q + 1'b1;
        default: ;
      endcase
    end
    if (qual) begin
      if (fill_last) begin
        cnt_d = '0;
        case (state_q)
          F_GAUSS: state_d = F_GRAD;
          F_GRAD:  state_d = F_SUPP;
          F_SUPP:  state_d = F_HYST;
          default: state_d = RUN;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A new frame wins over any move code presented on the same edge.
    if (start && (state_q == IDLE || state_q == RUN)) begin
      state_d = F_GAUSS;
      readx_d = '0;
      ready_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      readx_q <= '0;
      ready_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      readx_q <= readx_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_scan_position_tracker.sv
// Bench for scan_position_tracker: directed scenarios plus random traffic,
// compared each cycle against a stage/progress reference model.
module tb_scan_position_tracker;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       en9 = 1'b0, en7 = 1'b0, en5 = 1'b0, en3 = 1'b0;
  logic [1:0] gb = 2'b00;
  logic [8:0] readx, ready;
  logic       up_max, down_min, rdy_max;
  logic       d_gauss, d_grad, d_supp, d_hyst;

  int checks = 0;
  int fails  = 0;

  // Model: stage -1 idle, 0..3 filling, 4 running; prog counts qualifying shifts.
  int m_x = 0, m_y = 0, m_stage = -1, m_prog = 0;
  int need [4] = '{9, 7, 5, 3};

  always #5 clk = ~clk;

  scan_position_tracker dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .enable9x9(en9), .enable7x7(en7), .enable5x5(en5), .enable3x3(en3),
    .gaussian_buffer(gb),
    .readx(readx), .ready(ready),
    .readx_up_max(up_max), .readx_down_min(down_min), .ready_max(rdy_max),
    .gaussian_fill_done(d_gauss), .gradient_fill_done(d_grad),
    .suppression_fill_done(d_supp), .hysteresis_fill_done(d_hyst)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic stage_en(input int s);
    case (s)
      0: return en9;
      1: return en7;
      2: return en5;
      default: return en3;
    endcase
  endfunction

  function automatic int exp_done(input int s);
    return (m_stage == s && m_prog == need[s] - 1 && stage_en(s) && gb == 2'b01) ? 1 : 0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".readx"}, int'(readx), m_x);
    chk({tag, ".ready"}, int'(ready), m_y);
    chk({tag, ".up_max"}, int'(up_max), (m_stage == 4 && m_x == 511) ? 1 : 0);
    chk({tag, ".down_min"}, int'(down_min), (m_stage == 4 && m_x == 0) ? 1 : 0);
    chk({tag, ".ready_max"}, int'(rdy_max), (m_stage == 4 && m_y == 511) ? 1 : 0);
    chk({tag, ".gauss_done"}, int'(d_gauss), exp_done(0));
    chk({tag, ".grad_done"}, int'(d_grad), exp_done(1));
    chk({tag, ".supp_done"}, int'(d_supp), exp_done(2));
    chk({tag, ".hyst_done"}, int'(d_hyst), exp_done(3));
  endtask

  task automatic model_edge();
    if (start && (m_stage == -1 || m_stage == 4)) begin
      m_x = 0; m_y = 0; m_stage = 0; m_prog = 0;
    end else begin
      if (en9) begin
        if (gb == 2'b01) m_x = (m_x < 511) ? m_x + 1 : 511;
        if (gb == 2'b10) m_x = (m_x > 0) ? m_x - 1 : 0;
        if (gb == 2'b11) m_y = (m_y < 511) ? m_y + 1 : 511;
      end
      if (m_stage >= 0 && m_stage <= 3 && stage_en(m_stage) && gb == 2'b01) begin
        m_prog++;
        if (m_prog == need[m_stage]) begin m_prog = 0; m_stage++; end
      end
    end
  endtask

  // Called just after a negedge: apply inputs, check, take the rising edge.
  task automatic step(input string tag, input logic s, input logic [3:0] en, input logic [1:0] code);
    start = s; {en9, en7, en5, en3} = en; gb = code;
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_stage = -1; m_prog = 0;
  endtask

  initial begin
    // 1: reset state
    model_reset();
    @(negedge clk);
    check_all("reset");
    n_rst = 1'b1;
    @(negedge clk);
    step("idle", 1'b0, 4'hF, 2'b01);

    // 2: start then 24 right shifts with all enables
    step("start", 1'b1, 4'hF, 2'b01);
    for (int i = 1; i <= 24; i++) begin
      start = 1'b0; {en9, en7, en5, en3} = 4'hF; gb = 2'b01;
      #1;
      chk("fill.done_gauss", int'(d_gauss), (i == 9) ? 1 : 0);
      chk("fill.done_grad", int'(d_grad), (i == 16) ? 1 : 0);
      chk("fill.done_supp", int'(d_supp), (i == 21) ? 1 : 0);
      chk("fill.done_hyst", int'(d_hyst), (i == 24) ? 1 : 0);
      check_all("fill");
      @(posedge clk); model_edge(); @(negedge clk);
    end
    chk("run.readx24", int'(readx), 24);
    chk("run.stage", m_stage, 4);

    // 4a: down move from ready=0
    step("down0", 1'b0, 4'hF, 2'b11);
    chk("down0.ready1", int'(ready), 1);

    // 3: right to XMAX and saturate
    while (m_x < 511) step("right", 1'b0, 4'hF, 2'b01);
    #1 chk("xmax.flag", int'(up_max), 1);
    step("xsat", 1'b0, 4'hF, 2'b01);
    chk("xsat.readx", int'(readx), 511);

    // 4b: left to 0 and saturate
    while (m_x > 0) step("left", 1'b0, 4'hF, 2'b10);
    #1 chk("xmin.flag", int'(down_min), 1);
    step("xmin_sat", 1'b0, 4'hF, 2'b10);
    chk("xmin_sat.readx", int'(readx), 0);

    // 5: ready to YMAX and saturate
    while (m_y < 510) step("downs", 1'b0, 4'hF, 2'b11);
    step("y511", 1'b0, 4'hF, 2'b11);
    #1 chk("ymax.flag", int'(rdy_max), 1);
    step("ysat", 1'b0, 4'hF, 2'b11);
    chk("ysat.ready", int'(ready), 511);

    // Random traffic with occasional restarts and sparse stage enables
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 40) == 0), 4'($urandom), 2'($urandom));
    end

    // 6: async reset in the middle of the gradient fill
    step("rst_start", 1'b1, 4'hF, 2'b01);
    for (int i = 0; i < 11; i++) step("to_grad", 1'b0, 4'hF, 2'b01);
    chk("pre_rst.stage", m_stage, 1);
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.readx0", int'(readx), 0);
    @(negedge clk);
    n_rst = 1'b1;
    step("post_rst", 1'b0, 4'hF, 2'b01);
    step("restart", 1'b1, 4'hF, 2'b01);
    for (int i = 0; i < 24; i++) step("refill", 1'b0, 4'hF, 2'b01);
    while (m_x < 300) step("to300", 1'b0, 4'hF, 2'b01);
    chk("at300.readx", int'(readx), 300);
    step("start_run", 1'b1, 4'hF, 2'b10);
    chk("start_run.readx0", int'(readx), 0);
    step("after_start", 1'b0, 4'h0, 2'b00);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
